uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive engine for the SoC UART.
- Consumes the oversampled tick from the UART baud generator and deserialises the rx line (8N1 by default, LSB first) into bytes.
- Presents each byte on a valid/ready holding register.
- Drives rx_busy_o back to the baud generator, so a baud-rate change never lands mid-frame.

Parameters:
- OverSampleRate, 16, ticks per bit period; must be even and >= 4.
- DataBits, 8, data bits per frame; range 5..8.
- ParityOdd, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- baudx16_tick_i  in  1  one-cycle oversample strobe from the baud generator.
- rx_i  in  1  serial line, asynchronous to clk_i, idle high.
- rx_data_o  out  DataBits  received byte; stable while rx_valid_o is high.
- rx_valid_o  out  1  byte available.
- rx_ready_i  in  1  consumer accepts the byte when rx_valid_o and rx_ready_i are both high.
- rx_busy_o  out  1  high whenever the state is not IDLE.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err_o  out  1  one-cycle pulse: byte completed while the holding register was still full.
- parity_err_o  out  1  one-cycle pulse: parity mismatch. Present only with UART_RX_PARITY_EN.

Behaviour:
- Reset values: all outputs 0, rx_data_o 0, state IDLE, counters 0. Synchroniser flops and the edge-detect flop reset to 1 (idle line).
- Input path:
  - rx_i passes through a 2-flop synchroniser, giving rx_s.
  - rx_prev holds rx_s delayed one cycle.
  - The start condition is rx_prev=1 and rx_s=0. This is an edge, so a held-low break does not retrigger.
- Counter rules:
  - tick_cnt is $clog2(OverSampleRate) bits wide.
  - It advances only on cycles with baudx16_tick_i=1.
  - Every "sample" below happens on a tick cycle.
- State IDLE:
  - On the start condition, go to START with tick_cnt=0. The tick is not required in this cycle.
- State START:
  - On each tick, tick_cnt++.
  - On the tick where tick_cnt==OverSampleRate/2-1, sample rx_s (mid-bit).
  - Sample 0: go to DATA with tick_cnt=0 and bit_idx=0.
  - Sample 1: false start; go to IDLE with no error.
- State DATA:
  - On each tick, tick_cnt++.
  - At tick_cnt==OverSampleRate-1, sample rx_s into shift[bit_idx] (LSB first), clear tick_cnt, bit_idx++.
  - After bit DataBits-1, go to PARITY (macro on) or STOP (macro off).
- State PARITY (macro only):
  - Same timing as a data bit.
  - Computes err_p = (^shift ^ rx_s ^ ParityOdd) != 0; then go to STOP.
- State STOP:
  - Sample at tick_cnt==OverSampleRate-1, then go to IDLE.
  - Stop=0: pulse frame_err_o; byte discarded; rx_valid_o unchanged.
  - Stop=1 and err_p: pulse parity_err_o; byte discarded.
  - Stop=1, no parity error, holding register free: load rx_data_o, set rx_valid_o.
  - Stop=1, no parity error, holding register full: pulse overrun_err_o; new byte dropped; old byte kept.
- Holding register:
  - A handshake clears rx_valid_o on the next edge.
  - The holding register counts as free if a handshake occurs in the same cycle as the stop sample. The new byte then loads, rx_valid_o stays 1, and no overrun is reported.
- Latency:
  - rx_valid_o rises on the clock edge at the end of the stop-sample tick cycle.
  - Error pulses are registered with the same timing and last exactly one cycle.
- rx_busy_o is decoded from the state register, with no extra flop. It rises the cycle after the start edge is detected and falls with the return to IDLE.
- Tick stalls are allowed (gaps of any length). No timeout.
- Asynchronous reset mid-frame:
  - Immediately returns to IDLE and clears rx_valid_o and all pulses.
  - After release, a frame already in progress is recognised only from the next falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: PARITY state and parity_err_o port exist; frame = start + DataBits + parity + stop.
- Undefined: no PARITY state, no parity_err_o port; frame = start + DataBits + stop; ParityOdd is ignored.

Decomposition:
- Package uart_pkg holds:
  - The state enum: IDLE, START, DATA, PARITY, STOP.
  - Default OverSampleRate and DataBits constants, shared with the baud generator and the future transmitter.
- Sub-module sync_2ff: 2-flop synchroniser with a reset-value parameter. The bench and the future transmitter's CTS path reuse it.

Test Plan:
- Tick every 4 clk; serialise 0xA5, 8N1, 16 ticks per bit → rx_data_o=0xA5 and rx_valid_o=1 once; rx_busy_o high from the cycle after the start edge until the stop sample; no error pulses.
- Low glitch of 3 ticks on an idle line → START then IDLE; rx_valid_o stays 0; no frame_err_o.
- Frame 0x3C with stop bit 0, line then held low 40 bit times → one frame_err_o pulse, rx_valid_o=0, no re-entry to START until the line returns high and falls again.
- Send 0x11 and 0x22 back-to-back with rx_ready_i=0 → rx_data_o=0x11, one overrun_err_o pulse at the second stop sample. Repeat with rx_ready_i pulsed in the stop-sample cycle → rx_data_o=0x22, no overrun.
- With UART_RX_PARITY_EN and ParityOdd=0: 0x07 with parity bit 1 → accepted. 0x07 with parity bit 0 → one parity_err_o pulse, byte discarded.
- Assert rst_ni low mid-DATA of 0xFF → all outputs 0 asynchronously. Release; the next clean 0x5A frame → rx_data_o=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Used by the receiver, the baud generator and the future transmitter.
package uart_pkg;

    // Default oversample ticks per bit period.
    localparam int unsigned OverSampleRateDefault = 16;

    // Default data bits per frame.
    localparam int unsigned DataBitsDefault = 8;

    // Receiver frame states. PARITY is only entered when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // True for every state that belongs to a frame in progress.
    function automatic logic state_is_busy(input uart_state_e s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// ResetVal sets the value both flops hold during reset (e.g. 1 for an idle-high line).
module sync_2ff #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability filter: capture, then re-register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: oversampled deserialiser with a valid/ready holding register.
// Optional parity bit and parity_err_o port are enabled with `define UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OverSampleRate = OverSampleRateDefault,
    parameter int unsigned DataBits       = DataBitsDefault,
    parameter int unsigned ParityOdd      = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                baudx16_tick_i,
    input  logic                rx_i,
    output logic [DataBits-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                rx_busy_o,
    output logic                frame_err_o,
    output logic                overrun_err_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                parity_err_o
`endif
);

    localparam int unsigned TickW = $clog2(OverSampleRate);
    localparam int unsigned IdxW  = $clog2(DataBits);

    localparam logic [TickW-1:0] TickMid  = TickW'(OverSampleRate / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OverSampleRate - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DataBits - 1);

`ifdef UART_RX_PARITY_EN
    localparam logic ParityBit = 1'(ParityOdd);
`endif

    // Reject parameter combinations the frame timing cannot support.
    if (OverSampleRate < 4 || (OverSampleRate % 2) != 0) begin : g_bad_osr
        $error("uart_rx: OverSampleRate must be even and >= 4");
    end
    if (DataBits < 5 || DataBits > 8) begin : g_bad_bits
        $error("uart_rx: DataBits must be in 5..8");
    end
    if (ParityOdd > 1) begin : g_bad_parity
        $error("uart_rx: ParityOdd must be 0 or 1");
    end

    uart_state_e         state_q, state_d;
    logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic [DataBits-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_err_q, overrun_err_d;
    logic                rx_prev_q;
`ifdef UART_RX_PARITY_EN
    logic                perr_q, perr_d;
    logic                parity_err_q, parity_err_d;
`endif

    logic rx_s;
    logic start_edge;
    logic handshake;

    // Bring the asynchronous line into the clock domain; idle-high at reset.
    sync_2ff #(
        .ResetVal(1'b1)
    ) u_sync_rx (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    // Falling edge only, so a held-low break cannot retrigger a frame.
    assign start_edge = rx_prev_q && !rx_s;
    assign handshake  = rx_valid_q && rx_ready_i;

    // Next-state and datapath decode for the frame FSM.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q && !handshake;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d        = perr_q;
        parity_err_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end

            START: begin
                if (baudx16_tick_i) begin
                    if (tick_cnt_q == TickMid) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end

            DATA: begin
                if (baudx16_tick_i) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        // LSB arrives first, so shifting in at the top leaves bit 0 in shift[0].
                        shift_d = {rx_s, shift_q[DataBits-1:1]};
                        if (bit_idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + IdxW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baudx16_tick_i) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        perr_d     = (^shift_q) ^ rx_s ^ ParityBit;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
`endif

            STOP: begin
                if (baudx16_tick_i) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        if (!rx_s) begin
                            frame_err_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (perr_q) begin
                            parity_err_d = 1'b1;
                        end
`endif
                        // A same-cycle handshake frees the holding register for the new byte.
                        else if (!rx_valid_q || handshake) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_err_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, holding register and error pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            rx_prev_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_q        <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            rx_prev_q     <= rx_s;
`ifdef UART_RX_PARITY_EN
            perr_q        <= perr_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign frame_err_o   = frame_err_q;
    assign overrun_err_o = overrun_err_q;
    // Busy is a direct state decode so it tracks the frame without extra delay.
    assign rx_busy_o     = state_is_busy(state_q);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx (default 16x oversampling, 8 data bits).
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int unsigned Osr         = 16;
    localparam int unsigned ClksPerTick = 4;
    localparam int unsigned BitClks     = Osr * ClksPerTick;
`ifdef UART_RX_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif
    localparam int unsigned FrameTicks = Osr / 2 + Osr * 8 + (ParEn ? Osr : 0) + Osr;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    int n_asserts = 0;
    int n_fail    = 0;

    uart_rx #(
        .OverSampleRate(Osr),
        .DataBits      (8),
        .ParityOdd     (0)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .baudx16_tick_i(tick),
        .rx_i          (rx),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .rx_busy_o     (rx_busy),
        .frame_err_o   (frame_err),
        .overrun_err_o (overrun_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o  (parity_err)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oversample tick every 4th clock, changed on the falling edge.
    initial begin
        int phase;
        phase = 0;
        tick  = 1'b0;
        forever begin
            @(negedge clk);
            tick  = (phase == ClksPerTick - 1);
            phase = (phase + 1) % ClksPerTick;
        end
    end

    // Event monitor: counts output pulses and records when they happen.
    int   cyc = 0;
    int   valid_rises = 0, busy_rises = 0;
    int   ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
    int   valid_rise_cyc = -1, busy_fall_cyc = -1;
    int   ferr_cyc = -1, ovr_cyc = -1, perr_cyc = -1;
    logic valid_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        valid_prev <= rx_valid;
        busy_prev  <= rx_busy;
        if (rx_valid && !valid_prev) begin
            valid_rises    <= valid_rises + 1;
            valid_rise_cyc <= cyc;
        end
        if (rx_busy && !busy_prev) busy_rises <= busy_rises + 1;
        if (!rx_busy && busy_prev) busy_fall_cyc <= cyc;
        if (frame_err === 1'b1) begin
            ferr_cnt <= ferr_cnt + 1;
            ferr_cyc <= cyc;
        end
        if (overrun_err === 1'b1) begin
            ovr_cnt <= ovr_cnt + 1;
            ovr_cyc <= cyc;
        end
        if (parity_err === 1'b1) begin
            perr_cnt <= perr_cnt + 1;
            perr_cyc <= cyc;
        end
    end

    // Hard stop if something wedges the sequence.
    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leave the caller 1 time unit after a rising edge.
    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialise one frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        rx = 1'b0;
        clk_wait(BitClks);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            clk_wait(BitClks);
        end
        if (ParEn) begin
            rx = par_bit;
            clk_wait(BitClks);
        end
        rx = stop_bit;
        clk_wait(BitClks);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        clk_wait(1);
        rx_ready = 1'b0;
    endtask

    int b0, v0, f0, o0, p0;

    initial begin
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        clk_wait(3);

        // Reset state
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun_err), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        rst_n = 1'b1;
        clk_wait(10);

        // Clean 0xA5 frame, with busy latency from the start edge
        v0 = valid_rises;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        fork
            send_frame(8'hA5, ^8'hA5, 1'b1);
            begin
                clk_wait(2);
                check("a5_busy_pre", 32'(rx_busy), 32'h0);
                clk_wait(1);
                check("a5_busy_rise", 32'(rx_busy), 32'h1);
                clk_wait(BitClks * 5);
                check("a5_busy_mid", 32'(rx_busy), 32'h1);
            end
        join
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_valid", 32'(rx_valid), 32'h1);
        check("a5_valid_once", 32'(valid_rises - v0), 32'd1);
        check("a5_busy_end", 32'(rx_busy), 32'h0);
        check("a5_valid_at_stop", 32'(valid_rise_cyc), 32'(busy_fall_cyc));
        check("a5_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("a5_no_ovr", 32'(ovr_cnt - o0), 32'd0);
        consume();
        check("a5_consumed", 32'(rx_valid), 32'h0);

        // Short low glitch: false start, no error, no byte
        b0 = busy_rises;
        v0 = valid_rises;
        f0 = ferr_cnt;
        rx = 1'b0;
        clk_wait(3 * ClksPerTick);
        rx = 1'b1;
        clk_wait(200);
        check("glitch_one_start", 32'(busy_rises - b0), 32'd1);
        check("glitch_idle", 32'(rx_busy), 32'h0);
        check("glitch_valid", 32'(rx_valid), 32'h0);
        check("glitch_no_rise", 32'(valid_rises - v0), 32'd0);
        check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 0x3C with stop bit low, then a long break
        b0 = busy_rises;
        v0 = valid_rises;
        f0 = ferr_cnt;
        send_frame(8'h3C, ^8'h3C, 1'b0);
        clk_wait(40 * BitClks);
        check("ferr_one_pulse", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_at_stop", 32'(ferr_cyc), 32'(busy_fall_cyc));
        check("ferr_valid", 32'(rx_valid), 32'h0);
        check("ferr_no_rise", 32'(valid_rises - v0), 32'd0);
        check("ferr_no_reentry", 32'(busy_rises - b0), 32'd1);
        check("ferr_idle", 32'(rx_busy), 32'h0);
        rx = 1'b1;
        clk_wait(BitClks);
        check("ferr_release_idle", 32'(busy_rises - b0), 32'd1);

        // Back-to-back 0x11, 0x22 with no consumer: overrun keeps 0x11
        v0 = valid_rises;
        o0 = ovr_cnt;
        send_frame(8'h11, ^8'h11, 1'b1);
        send_frame(8'h22, ^8'h22, 1'b1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_one_pulse", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_at_2nd_stop", 32'(ovr_cyc), 32'(busy_fall_cyc));
        check("ovr_valid_once", 32'(valid_rises - v0), 32'd1);
        consume();
        check("ovr_consumed", 32'(rx_valid), 32'h0);

        // Same pair, consumer handshakes in the second stop-sample cycle
        v0 = valid_rises;
        o0 = ovr_cnt;
        send_frame(8'h11, ^8'h11, 1'b1);
        check("hs_first", 32'(rx_data), 32'h11);
        fork
            send_frame(8'h22, ^8'h22, 1'b1);
            begin
                int t;
                t = 0;
                clk_wait(3);
                while (t < int'(FrameTicks)) begin
                    @(negedge clk);
                    #1;
                    if (tick) t++;
                    if (t == int'(FrameTicks)) rx_ready = 1'b1;
                    @(posedge clk);
                    #1;
                end
                rx_ready = 1'b0;
                check("hs_load_data", 32'(rx_data), 32'h22);
                check("hs_load_valid", 32'(rx_valid), 32'h1);
                check("hs_load_idle", 32'(rx_busy), 32'h0);
            end
        join
        check("hs_no_ovr", 32'(ovr_cnt - o0), 32'd0);
        check("hs_valid_held", 32'(valid_rises - v0), 32'd1);
        check("hs_data_end", 32'(rx_data), 32'h22);

`ifdef UART_RX_PARITY_EN
        // Even parity on 0x07: parity bit 1 is correct, 0 is an error
        consume();
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_ok_data", 32'(rx_data), 32'h07);
        check("par_ok_valid", 32'(rx_valid), 32'h1);
        check("par_ok_no_err", 32'(perr_cnt - p0), 32'd0);
        consume();
        v0 = valid_rises;
        send_frame(8'h07, 1'b0, 1'b1);
        check("par_bad_pulse", 32'(perr_cnt - p0), 32'd1);
        check("par_bad_at_stop", 32'(perr_cyc), 32'(busy_fall_cyc));
        check("par_bad_valid", 32'(rx_valid), 32'h0);
        check("par_bad_no_rise", 32'(valid_rises - v0), 32'd0);
`endif

        // Asynchronous reset in the middle of 0xFF
        fork
            send_frame(8'hFF, ^8'hFF, 1'b1);
            begin
                clk_wait(BitClks * 3);
                rst_n = 1'b0;
                #2;
                check("arst_data", 32'(rx_data), 32'h0);
                check("arst_valid", 32'(rx_valid), 32'h0);
                check("arst_busy", 32'(rx_busy), 32'h0);
                check("arst_ferr", 32'(frame_err), 32'h0);
                check("arst_ovr", 32'(overrun_err), 32'h0);
                check("arst_perr", 32'(parity_err), 32'h0);
                clk_wait(5);
                rst_n = 1'b1;
            end
        join
        clk_wait(BitClks);
        check("arst_after_valid", 32'(rx_valid), 32'h0);
        check("arst_after_busy", 32'(rx_busy), 32'h0);

        // Clean 0x5A after reset
        f0 = ferr_cnt;
        send_frame(8'h5A, ^8'h5A, 1'b1);
        check("post_data", 32'(rx_data), 32'h5A);
        check("post_valid", 32'(rx_valid), 32'h1);
        check("post_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        clk_wait(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
